// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: command bytes, host-transmit FSM states, default timing.
// Ports: none (package only).
// Timing defaults assume a 50 MHz system clock.
package ps2_pkg;

  // Common keyboard command / response bytes
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Default timing at 50 MHz
  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;    // 100 us clock-low inhibit
  localparam int unsigned DEF_START_TIMEOUT  = 750000;  // 15 ms wait for first device clock
  localparam int unsigned DEF_PACKET_TIMEOUT = 100000;  // 2 ms first edge to ACK
  localparam int unsigned DEF_SYNC_STAGES    = 2;

  localparam int CNT_W = 20;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_REQUEST,
    TX_SEND,
    TX_ACK,
    TX_WAIT_IDLE,
    TX_FAIL
  } tx_state_e;

  // Saturating increment: timers stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line synchronizer: SYNC_STAGES flops on clock and data, plus clock falling-edge detect.
// Ports: clk_i/rst_i system clock and sync reset; ps2_clk_i/ps2_dat_i raw pads;
//        sync_clk_o/sync_dat_o synchronized levels; clk_fall_o one-cycle falling-edge strobe.
module ps2_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic sync_clk_o,
  output logic sync_dat_o,
  output logic clk_fall_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;

  // Reset to the idle (released, pulled-up) line level so no false edge follows reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q[0] <= ps2_clk_i;
      dat_sync_q[0] <= ps2_dat_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        clk_sync_q[i] <= clk_sync_q[i-1];
        dat_sync_q[i] <= dat_sync_q[i-1];
      end
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_clk_o = clk_sync_q[SYNC_STAGES-1];
  assign sync_dat_o = dat_sync_q[SYNC_STAGES-1];
  assign clk_fall_o = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Ports: CLOCK_50/reset; tx_data/tx_valid/tx_ready request handshake; ps2_*_in raw pads;
//        ps2_*_oe open-drain pull-low enables; busy; tx_done/tx_error one-cycle result pulses.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int unsigned PACKET_TIMEOUT = DEF_PACKET_TIMEOUT,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PACKET_LAST  = CNT_W'(PACKET_TIMEOUT - 1);

  logic sync_clk, sync_dat, clk_fall;

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i     (CLOCK_50),
    .rst_i     (reset),
    .ps2_clk_i (ps2_clk_in),
    .ps2_dat_i (ps2_dat_in),
    .sync_clk_o(sync_clk),
    .sync_dat_o(sync_dat),
    .clk_fall_o(clk_fall)
  );

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;          // per-state timer, cleared on every state entry
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;  // cycles since the first device falling edge
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic             dat_bit_q, dat_bit_d;  // frame bit currently presented on the data line
  logic             next_bit;

  // Bit to present for the current index: D1..D7, then parity, then stop (released).
  assign next_bit = (bit_idx_q <= 4'd7) ? data_q[bit_idx_q[2:0]] :
                    (bit_idx_q == 4'd8) ? parity_q : 1'b1;

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    parity_d   = parity_q;
    dat_bit_d  = dat_bit_q;
    tx_ready   = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    busy       = 1'b1;
    tx_done    = 1'b0;
    tx_error   = 1'b0;

    case (state_q)
      TX_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) begin
          data_d   = tx_data;
          parity_d = ~^tx_data;
          state_d  = TX_INHIBIT;
        end
      end

      TX_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q >= INHIBIT_LAST) state_d = TX_REQUEST;
      end

      TX_REQUEST: begin
        ps2_dat_oe = 1'b1;  // start bit
        if (clk_fall) begin
          dat_bit_d = data_q[0];
          bit_idx_d = 4'd1;
          state_d   = TX_SEND;
        end else if (cnt_q >= START_LAST) begin
          state_d = TX_FAIL;
        end
      end

      TX_SEND: begin
        ps2_dat_oe = ~dat_bit_q;  // only zeros are actively driven
        if (clk_fall) begin
          dat_bit_d = next_bit;
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) state_d = TX_ACK;
        end else if (pkt_cnt_q >= PACKET_LAST) begin
          state_d = TX_FAIL;
        end
      end

      TX_ACK: begin
        if (clk_fall) begin
          state_d = sync_dat ? TX_FAIL : TX_WAIT_IDLE;
        end else if (pkt_cnt_q >= PACKET_LAST) begin
          state_d = TX_FAIL;
        end
      end

      TX_WAIT_IDLE: begin
        if (sync_clk && sync_dat) begin
          tx_done = 1'b1;
          state_d = TX_IDLE;
        end else if (pkt_cnt_q >= PACKET_LAST) begin
          state_d = TX_FAIL;
        end
      end

      TX_FAIL: begin
        tx_error = 1'b1;
        state_d  = TX_IDLE;
      end

      default: state_d = TX_IDLE;
    endcase

    cnt_d = (state_d != state_q) ? '0 : sat_inc(cnt_q);

    // The packet timer spans SEND..WAIT_IDLE, so it is not cleared between those states.
    // Loading 1 while in REQUEST makes it equal the cycle count since the edge was detected.
    case (state_q)
      TX_REQUEST:                      pkt_cnt_d = CNT_W'(1);
      TX_SEND, TX_ACK, TX_WAIT_IDLE:   pkt_cnt_d = sat_inc(pkt_cnt_q);
      default:                         pkt_cnt_d = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      pkt_cnt_q <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      dat_bit_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      dat_bit_q <= dat_bit_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH    = 50;
  localparam int ST_TO  = 3000;
  localparam int PKT_TO = 1500;
  localparam int HALF   = 40;
  localparam int SS     = 2;

  localparam logic [1:0] R_DONE = 2'b01;
  localparam logic [1:0] R_ERR  = 2'b10;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  longint cyc = 0;
  int     chk_cnt = 0;
  int     pass_cnt = 0;

  logic [10:0] exp_frame_q[$];
  logic [1:0]  exp_resp_q[$];

  logic [10:0] got;
  longint      t0;
  int          n;

  // Open-drain wired-AND of host and device
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (ST_TO),
    .PACKET_TIMEOUT(PKT_TO),
    .SYNC_STAGES   (SS)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge CLOCK_50);
  endtask

  // Response monitor: every done/error pulse is matched against the scoreboard
  always @(negedge CLOCK_50) begin
    if (tx_done || tx_error) begin
      check("done_err_exclusive", 32'(tx_done & tx_error), 32'd0);
      if (exp_resp_q.size() == 0) check("resp_unexpected", 32'({tx_error, tx_done}), 32'd0);
      else check("resp_kind", 32'({tx_error, tx_done}), 32'(exp_resp_q.pop_front()));
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLOCK_50);
    check("accept_ready", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
    tx_data  = 8'h00;  // latched copy must be used from here on
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_resp(input int bound);
    int k = 0;
    while (exp_resp_q.size() != 0 && k < bound) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("resp_arrived", 32'(exp_resp_q.size()), 32'd0);
    wait_cyc(2);
  endtask

  // Device model: waits for request-to-send, samples start, then clocks n_fall falling
  // edges, sampling data on each rising edge. A partial frame returns with clock held low.
  task automatic dev_xfer(input int n_fall, input bit give_ack,
                          output logic [10:0] bits, output longint t_first);
    int k = 0;
    bits    = '0;
    t_first = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && k < INH + 200) begin
      @(negedge CLOCK_50);
      k++;
    end
    check("dev_request_seen", 32'(ps2_dat_oe && !ps2_clk_oe), 32'd1);
    wait_cyc(10);
    bits[0] = ps2_dat_in;
    for (int e = 1; e <= n_fall; e++) begin
      if (e == 11 && give_ack) begin
        dev_dat_low = 1'b1;
        wait_cyc(4);
      end
      dev_clk_low = 1'b1;
      if (e == 1) t_first = cyc;
      if (e < 11 && e == n_fall) break;
      wait_cyc(HALF);
      dev_clk_low = 1'b0;
      if (e <= 10) bits[e] = ps2_dat_in;
      wait_cyc(HALF);
    end
    if (n_fall == 11) begin
      dev_dat_low = 1'b0;
      if (exp_frame_q.size() == 0) check("frame_unexpected", 32'(bits), 32'h0);
      else check("frame_bits", 32'(bits), 32'(exp_frame_q.pop_front()));
    end
  endtask

  initial begin
    repeat (200000) @(posedge CLOCK_50);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    wait_cyc(5);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'({tx_done, tx_error}), 32'd0);
    reset = 1'b0;
    wait_cyc(5);

    // 0xED: frame LSB first 0,1,0,1,1,0,1,1,1,1,1 -> {stop,par,D7..D0,start}=0x7DA
    exp_frame_q.push_back(11'h7DA);
    exp_resp_q.push_back(R_DONE);
    send_byte(8'hED);
    n = 0;
    while (ps2_clk_oe && n < INH + 100) begin
      n++;
      @(negedge CLOCK_50);
    end
    check("inhibit_len", 32'(n), 32'(INH));
    check("request_dat_oe", 32'(ps2_dat_oe), 32'd1);
    dev_xfer(11, 1'b1, got, t0);
    wait_resp(400);
    check("done_ready_back", 32'(tx_ready), 32'd1);

    // NACK on 0x01: frame {1,0,0x01,0}=0x402, device leaves data high
    exp_frame_q.push_back(11'h402);
    exp_resp_q.push_back(R_ERR);
    send_byte(8'h01);
    dev_xfer(11, 1'b0, got, t0);
    wait_resp(400);

    // No device response: request held START_TIMEOUT cycles, then error
    exp_resp_q.push_back(R_ERR);
    send_byte(8'hF4);
    n = 0;
    while (!ps2_dat_oe && n < INH + 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    n = 0;
    while (ps2_dat_oe && n < ST_TO + 100) begin
      n++;
      @(negedge CLOCK_50);
    end
    check("start_timeout_len", 32'(n), 32'(ST_TO));
    check("start_timeout_err", 32'(tx_error), 32'd1);
    check("fail_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    @(negedge CLOCK_50);
    check("fail_to_idle", 32'(tx_ready), 32'd1);
    wait_resp(50);

    // Reset after 5th falling edge while D4 of 0xED (a zero) is driven
    send_byte(8'hED);
    dev_xfer(5, 1'b1, got, t0);
    wait_cyc(8);
    check("mid_dat_oe", 32'(ps2_dat_oe), 32'd1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("mid_rst_lines", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_pulses", 32'({tx_done, tx_error}), 32'd0);
    reset = 1'b0;
    dev_clk_low = 1'b0;
    wait_cyc(20);

    // 0xF4 after reset: parity 0 -> {1,0,0xF4,0}=0x5E8
    exp_frame_q.push_back(11'h5E8);
    exp_resp_q.push_back(R_DONE);
    send_byte(8'hF4);
    dev_xfer(11, 1'b1, got, t0);
    wait_resp(400);

    // 0xFF with a 0x00 request injected mid-frame: {1,1,0xFF,0}=0x7FE, one done only
    exp_frame_q.push_back(11'h7FE);
    exp_resp_q.push_back(R_DONE);
    send_byte(8'hFF);
    fork
      dev_xfer(11, 1'b1, got, t0);
      begin
        wait_cyc(INH + 10 + 4 * 2 * HALF);
        check("busy_not_ready", 32'({busy, tx_ready}), 32'b10);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
      end
    join
    wait_resp(400);
    wait_cyc(30);
    check("busy_req_dropped", 32'({ps2_clk_oe, tx_ready}), 32'b01);

    // Packet timeout: device stops after edge 6
    exp_resp_q.push_back(R_ERR);
    send_byte(8'hED);
    dev_xfer(6, 1'b1, got, t0);
    dev_clk_low = 1'b0;
    n = 0;
    while (!tx_error && n < PKT_TO + 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (tx_error && (cyc - t0) >= PKT_TO && (cyc - t0) <= PKT_TO + SS + 1)
      check("pkt_timeout_latency", 32'(PKT_TO), 32'(PKT_TO));
    else
      check("pkt_timeout_latency", 32'(cyc - t0), 32'(PKT_TO));
    wait_resp(50);
    check("pkt_timeout_idle", 32'({tx_ready, ps2_clk_oe, ps2_dat_oe}), 32'b100);

    check("frames_consumed", 32'(exp_frame_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
